// File: rtl/obi_mbox_resp.sv
// OBI mailbox slave: TX FIFO toward the MCU (TXDATA/CTRL) plus a one-word RX mailbox from it (RXDATA/STATUS); OBI_MBOX_DROP_ON_FULL_EN selects drop-on-full.
// Latency: gnt is combinational, rvalid/rdata one cycle after each grant; the MCU side sees pushes one cycle later.
// Backpressure: a TXDATA write to a full FIFO holds gnt low until it drains, unless drop-on-full is built in (then the word is dropped and ovf set).

module obi_mbox_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic [W-1:0]            wdata,
    input  logic                    pop,
    output logic [W-1:0]            rdata,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head reads as zero when empty so stale storage never leaks out.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module obi_mbox_resp #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         we,
    input  logic [3:0]                   be,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic                         gnt,
    output logic                         rvalid,
    output logic [31:0]                  rdata,
    input  logic                         mcu_pop,
    output logic [31:0]                  mcu_rdata,
    output logic                         mcu_empty,
    output logic [$clog2(FIFO_DEPTH):0]  mcu_level,
    input  logic                         mcu_push,
    input  logic [31:0]                  mcu_wdata,
    output logic                         mcu_rx_pending
);
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1;

    logic        fifo_full;
    logic        tx_wr_req;
    logic        tx_push;
    logic        ctrl_wr;
    logic        flush;
    logic        rx_rd;
    logic        ovf;
    logic [31:0] rx_word;
    logic [31:0] tx_word;
    logic [31:0] status;
    logic [31:0] rd_mux;
    logic [7:0]  level8;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign tx_wr_req = req & we & (addr[3:2] == REG_TXDATA);

`ifdef OBI_MBOX_DROP_ON_FULL_EN
    assign gnt = req;
`else
    // Stall on registered fullness only, so a same-cycle pop cannot release it.
    assign gnt = req & ~(~rst & tx_wr_req & fifo_full);
`endif

    assign tx_push = gnt & tx_wr_req;
    assign ctrl_wr = gnt & we & (addr[3:2] == REG_CTRL);
    assign flush   = ctrl_wr & wdata[0];
    assign rx_rd   = gnt & ~we & (addr[3:2] == REG_RXDATA);

    assign tx_word = wdata & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    obi_mbox_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (tx_push),
        .wdata (tx_word),
        .pop   (mcu_pop),
        .rdata (mcu_rdata),
        .empty (mcu_empty),
        .full  (fifo_full),
        .level (mcu_level)
    );

`ifdef OBI_MBOX_DROP_ON_FULL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (tx_push && fifo_full) begin
            ovf <= 1'b1;
        end else if (ctrl_wr && wdata[1]) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    assign level8 = {{(8-LW){1'b0}}, mcu_level};
    assign status = {20'h0, ovf, mcu_rx_pending, mcu_empty, fifo_full, level8};

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_STATUS: rd_mux = status;
            REG_RXDATA: rd_mux = rx_word;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid         <= 1'b0;
            rdata          <= '0;
            rx_word        <= '0;
            mcu_rx_pending <= 1'b0;
        end else begin
            rvalid <= gnt;
            rdata  <= (gnt && !we) ? rd_mux : '0;
            // A fresh MCU word outranks the read that consumes the old one.
            if (mcu_push) begin
                rx_word        <= mcu_wdata;
                mcu_rx_pending <= 1'b1;
            end else if (rx_rd) begin
                mcu_rx_pending <= 1'b0;
            end
        end
    end
endmodule
